priority_irq_encoder: RTL and testbench
=======================================

# priority_irq_encoder

Parametrised, registered successor to the team's 8-to-3 priority encoder. It captures N active-low request lines into sticky pending bits and applies a per-line mask. It selects one unmasked pending line, presents its index with a valid/ack handshake, and clears that line on acknowledge. It sits between raw event/interrupt sources and a consumer FSM, and keeps the gs/en_out cascade semantics of the combinational encoder.

## Interface
- N, 8: number of request lines; legal range 2..32.
- W, $clog2(N): index width; derived, not overridden.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en_in_n  in  1  active-low block enable
- req_n  in  N  active-low request lines, sampled each clk
- mask  in  N  1 = line excluded from selection; capture is unaffected
- ack  in  1  consumer accepts current index
- y  out  W  granted index, active-high binary
- valid  out  1  y is a live grant
- gs  out  1  group select: enabled and at least one unmasked pending bit
- en_out  out  1  cascade enable: enabled and no unmasked pending bit

## Operation
- Capture: every edge, pending[i] <= pending[i] | ~req_n[i].
  - Capture runs regardless of en_in_n or mask.
  - A request held low for multiple cycles is one event until it is cleared.
- Selection: cand = pending & ~mask. Fixed priority: the highest index wins.
- States: IDLE and GRANT.
- IDLE:
  - If en_in_n==0 and cand!=0, register the winner into y, set valid=1, and go to GRANT.
  - Otherwise stay in IDLE with valid=0.
- GRANT:
  - y and valid are held stable until ack=1.
  - Mask changes and new requests do not alter y.
  - On ack: clear pending[y], set valid=0, go to IDLE.
- Ack and capture on the same line in the same cycle: the set wins, and pending[y] stays 1 as a new event.
- Ack while in IDLE is ignored.
- en_in_n rising while in GRANT: abort to IDLE, valid=0, pending[y] retained.
- en_in_n==1 forces gs=0, en_out=0 and valid=0. y holds its last value.
- gs and en_out are combinational from pending, mask and en_in_n. They never depend on req_n directly.

## Timing
- Reset values:
  - pending=0, state=IDLE, y=0, valid=0.
  - gs=0; en_out = ~en_in_n.
  - Rotation pointer = N-1.
- Latency:
  - req_n[i] low before edge k makes pending[i] set at edge k; gs and en_out change after edge k.
  - valid rises at edge k+1 if the block is IDLE and enabled.
- After an ack at edge m, valid is low for at least cycle m..m+1. The earliest next grant is at edge m+1.
- One grant is outstanding at most.
- Reset is asynchronous. Asserting it mid-GRANT drops valid immediately and discards all pending bits.

## Configuration
- PRIO_ROTATE_EN defined: round-robin selection.
  - Register ptr, reset to N-1.
  - The search runs downward from ptr with wrap-around (ptr, ptr-1, …, 0, N-1, …).
  - On ack, ptr <= (y==0) ? N-1 : y-1.
  - Abort via en_in_n leaves ptr unchanged.
- PRIO_ROTATE_EN undefined: fixed highest-index priority.
  - No ptr register is synthesised.

## Test plan
- Reset, then N=8, req_n=8'hFF, en_in_n=0 -> valid=0, gs=0, en_out=1, y=0.
- Fixed priority: pulse req_n bits 2 and 6 low for one cycle -> gs=1 after edge; valid=1 with y=6 next edge; ack -> y=2 after one idle cycle; ack -> gs=0, en_out=1.
- Mask: pending 6 and 2 with mask=8'h40 -> y=2; clear mask during GRANT -> y stays 2 until ack, then y=6.
- Simultaneous ack and re-request on line 5 -> pending[5] remains 1, and line 5 is re-granted after one idle cycle.
- Abort: en_in_n=1 during GRANT y=3 -> valid=0, gs=0, en_out=0; en_in_n=0 -> y=3 granted again.
- PRIO_ROTATE_EN: lines 7 and 1 held low continuously -> grants alternate 7, 1, 7, 1 across consecutive acks. Without the macro -> grants are 7 every time.

Source files
------------

// File: rtl/priority_irq_encoder.sv
// priority_irq_encoder: sticky active-low request capture, masked priority grant with valid/ack handshake (PRIO_ROTATE_EN selects round-robin)
module priority_irq_encoder #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_in_n,
   input  logic [N-1:0] req_n,
   input  logic [N-1:0] mask,
   input  logic         ack,
   output logic [W-1:0] y,
   output logic         valid,
   output logic         gs,
   output logic         en_out
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_nxt;
   logic [N-1:0] pending, cand, clr;
   logic [W-1:0] win;
   logic go, done;
   assign cand   = pending & ~mask;
   assign go     = (state == IDLE) && !en_in_n && |cand;
   assign done   = (state == GRANT) && !en_in_n && ack;
   assign clr    = done ? N'(1) << y : '0;
   assign valid  = (state == GRANT) && !en_in_n;
   assign gs     = !en_in_n && |cand;
   assign en_out = !en_in_n && !(|cand);
`ifdef PRIO_ROTATE_EN
   logic [W-1:0] ptr;
   // round-robin: scan downward from ptr with wrap; the entry closest to ptr is assigned last and wins
   always_comb begin
      win = '0;
      for (int i = N - 1; i >= 0; i--)
         if (cand[(int'(ptr) - i + N) % N]) win = W'((int'(ptr) - i + N) % N);
   end
   // rotation pointer moves just below the line that was acknowledged; aborts leave it alone
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= W'(N - 1);
      else if (done) ptr <= (y == '0) ? W'(N - 1) : y - 1'b1;
`else
   // fixed priority: highest set candidate index wins
   always_comb begin
      win = '0;
      for (int i = 0; i < N; i++)
         if (cand[i]) win = W'(i);
   end
`endif
   // next state: grant when enabled with a candidate; leave GRANT on ack or on disable (abort)
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (go ? GRANT : IDLE) : ((en_in_n || ack) ? IDLE : GRANT);
   end
   // state, sticky pending capture (new request beats ack clear) and registered grant index
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
         y       <= '0;
      end else begin
         state   <= state_nxt;
         pending <= (pending & ~clr) | ~req_n;
         y       <= go ? win : y;
      end
endmodule

// File: tb/tb_priority_irq_encoder.sv
// tb_priority_irq_encoder: scoreboard bench for priority_irq_encoder (N=8), expectations follow PRIO_ROTATE_EN
module tb_priority_irq_encoder;
   localparam int N = 8;
   logic clk = 0, rst = 1, en_in_n = 0, ack = 0;
   logic [N-1:0] req_n = '1, mask = '0;
   logic [2:0] y;
   logic valid, gs, en_out;
   int checks = 0, errors = 0;
   int exp_q[$];

   priority_irq_encoder #(.N(N)) dut (
      .clk(clk), .rst(rst), .en_in_n(en_in_n), .req_n(req_n), .mask(mask),
      .ack(ack), .y(y), .valid(valid), .gs(gs), .en_out(en_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // wait (bounded) for a grant, compare against scoreboard head, ack it; rr = lines re-requested on the ack edge
   task automatic serve(input string tag, input logic [N-1:0] rr);
      int t = 0;
      int e;
      while (!valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!valid) begin
         chk({tag, "_timeout"}, 0, 1);
         return;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk({tag, "_y"}, 32'(y), e);
      ack = 1;
      req_n = req_n & ~rr;
      @(negedge clk);
      ack = 0;
      req_n = req_n | rr;
      chk({tag, "_idle"}, 32'(valid), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(valid), 0);
      rst = 0;
      @(negedge clk);
      chk("reset_valid", 32'(valid), 0);
      chk("reset_gs", 32'(gs), 0);
      chk("reset_en_out", 32'(en_out), 1);
      chk("reset_y", 32'(y), 0);

      // fixed priority: lines 6 and 2 pulsed together
      req_n = ~8'h44;
      exp_q.push_back(6);
      exp_q.push_back(2);
      @(negedge clk);
      req_n = '1;
      chk("prio_gs", 32'(gs), 1);
      chk("prio_en_out", 32'(en_out), 0);
      chk("prio_valid_lat", 32'(valid), 0);
      @(negedge clk);
      chk("prio_valid", 32'(valid), 1);
      serve("prio1", '0);
      @(negedge clk);
      chk("prio_next_lat", 32'(valid), 1);
      serve("prio2", '0);
      chk("prio_done_gs", 32'(gs), 0);
      chk("prio_done_en_out", 32'(en_out), 1);

      // mask excludes line 6; unmasking mid-grant must not disturb y
      mask = 8'h40;
      req_n = ~8'h44;
      exp_q.push_back(2);
      exp_q.push_back(6);
      @(negedge clk);
      req_n = '1;
      chk("mask_gs", 32'(gs), 1);
      @(negedge clk);
      chk("mask_valid", 32'(valid), 1);
      chk("mask_y", 32'(y), 2);
      mask = '0;
      repeat (2) begin
         @(negedge clk);
         chk("mask_hold_y", 32'(y), 2);
         chk("mask_hold_valid", 32'(valid), 1);
      end
      serve("mask1", '0);
      serve("mask2", '0);

      // ack and re-request of line 5 on the same edge
      req_n = ~8'h20;
      exp_q.push_back(5);
      exp_q.push_back(5);
      @(negedge clk);
      req_n = '1;
      serve("rereq1", 8'h20);
      chk("rereq_gs", 32'(gs), 1);
      @(negedge clk);
      chk("rereq_lat", 32'(valid), 1);
      serve("rereq2", '0);
      chk("rereq_empty", 32'(gs), 0);

      // abort via en_in_n during grant of line 3
      req_n = ~8'h08;
      exp_q.push_back(3);
      @(negedge clk);
      req_n = '1;
      @(negedge clk);
      chk("abort_pre_valid", 32'(valid), 1);
      chk("abort_pre_y", 32'(y), 3);
      en_in_n = 1;
      #1;
      chk("abort_comb_valid", 32'(valid), 0);
      @(negedge clk);
      chk("abort_valid", 32'(valid), 0);
      chk("abort_gs", 32'(gs), 0);
      chk("abort_en_out", 32'(en_out), 0);
      chk("abort_y_hold", 32'(y), 3);
      @(negedge clk);
      chk("abort_stay", 32'(valid), 0);
      en_in_n = 0;
      @(negedge clk);
      chk("abort_regrant", 32'(valid), 1);
      serve("abort", '0);

      // rotation: restart from reset so the pointer is back at N-1
      rst = 1;
      @(negedge clk);
      rst = 0;
      req_n = ~8'h82;
`ifdef PRIO_ROTATE_EN
      exp_q = '{7, 1, 7, 1};
`else
      exp_q = '{7, 7, 7, 7};
`endif
      for (int k = 0; k < 3; k++) serve("rot", '0);
      begin
         int t = 0;
         while (!valid && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      chk("rot4_valid", 32'(valid), 1);
      chk("rot4_y", 32'(y), exp_q.pop_front());

      // asynchronous reset mid-grant drops valid at once and discards pending
      #2 rst = 1;
      #1;
      chk("async_valid", 32'(valid), 0);
      req_n = '1;
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("async_gs", 32'(gs), 0);
      chk("async_en_out", 32'(en_out), 1);
      chk("async_valid2", 32'(valid), 0);
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
